fft_result_reader: RTL and testbench

- Unloads a completed FFT frame from the FFT core's result RAM (`read_addr` / `dataout_re` / `dataout_im` side of `top`).
- After `fft_finish` rises, it sweeps the read address, compensates for the fixed RAM read latency and streams the N complex bins out on a valid/ready interface with a last flag.
- It is the reader counterpart to the serial sample loader that feeds `initial_en` / `datain_*`.

---
 rtl/fft_result_reader.sv | 171 +++++++++++++++++
 tb/tb_fft_result_reader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_result_reader.sv
// Unloads a finished FFT frame from the result RAM and streams the bins on valid/ready.
// Define FFT_READER_BITREV_EN to read the RAM in bit-reversed address order.
module fft_result_reader #(
   parameter int unsigned N      = 512,
   parameter int unsigned L_max  = 9,
   parameter int unsigned DW     = 24,
   parameter int unsigned RD_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fft_finish,
   output logic [L_max-1:0] read_addr,
   input  logic [DW-1:0]    dataout_re,
   input  logic [DW-1:0]    dataout_im,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DW-1:0]    out_re,
   output logic [DW-1:0]    out_im,
   output logic [L_max-1:0] out_index,
   output logic             out_last,
   output logic             busy,
   output logic             done
);

   localparam int unsigned      Depth   = 4;
   localparam logic [L_max-1:0] LastIdx = L_max'(N - 1);

   typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

   state_e            state_q, state_d;
   logic              fin_q;
   logic [L_max-1:0]  cnt_q, cnt_d;
   logic              iss_vld_q, iss_vld_d;
   logic [L_max-1:0]  iss_idx_q, iss_idx_d;
   logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
   logic [L_max-1:0]  tag_idx_q [RD_LAT];
   logic [L_max-1:0]  tag_idx_d [RD_LAT];
   logic [DW-1:0]     fifo_re_q [Depth];
   logic [DW-1:0]     fifo_re_d [Depth];
   logic [DW-1:0]     fifo_im_q [Depth];
   logic [DW-1:0]     fifo_im_d [Depth];
   logic [L_max-1:0]  fifo_idx_q [Depth];
   logic [L_max-1:0]  fifo_idx_d [Depth];
   logic [1:0]        wr_ptr_q, wr_ptr_d;
   logic [1:0]        rd_ptr_q, rd_ptr_d;
   logic [2:0]        count_q, count_d;
   logic              done_q, done_d;

   logic              push, pop;
   logic [2:0]        inflight;
   logic [3:0]        occ;

   function automatic logic [L_max-1:0] map_addr(input logic [L_max-1:0] a);
      logic [L_max-1:0] r;
`ifdef FFT_READER_BITREV_EN
      for (int i = 0; i < L_max; i++) r[i] = a[L_max-1-i];
`else
      r = a;
`endif
      return r;
   endfunction

   assign read_addr = map_addr(iss_idx_q);
   assign out_valid = (count_q != 3'd0);
   assign out_re    = fifo_re_q[rd_ptr_q];
   assign out_im    = fifo_im_q[rd_ptr_q];
   assign out_index = fifo_idx_q[rd_ptr_q];
   assign out_last  = out_valid && (fifo_idx_q[rd_ptr_q] == LastIdx);
   assign busy      = (state_q != StIdle);
   assign done      = done_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      iss_vld_d  = 1'b0;
      iss_idx_d  = iss_idx_q;
      tag_vld_d  = tag_vld_q;
      tag_idx_d  = tag_idx_q;
      fifo_re_d  = fifo_re_q;
      fifo_im_d  = fifo_im_q;
      fifo_idx_d = fifo_idx_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      done_d     = 1'b0;

      push = tag_vld_q[RD_LAT-1];
      pop  = out_valid && out_ready;

      // Reads already issued will land in the FIFO; a slot freed by this cycle's pop is reusable.
      inflight = {2'b00, iss_vld_q};
      for (int i = 0; i < RD_LAT; i++) inflight = inflight + {2'b00, tag_vld_q[i]};
      occ = {1'b0, inflight} + {1'b0, count_q} - {3'b000, pop};

      tag_vld_d[0] = iss_vld_q;
      tag_idx_d[0] = iss_idx_q;
      for (int i = 1; i < RD_LAT; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_idx_d[i] = tag_idx_q[i-1];
      end

      if (push) begin
         fifo_re_d[wr_ptr_q]  = dataout_re;
         fifo_im_d[wr_ptr_q]  = dataout_im;
         fifo_idx_d[wr_ptr_q] = tag_idx_q[RD_LAT-1];
         wr_ptr_d             = wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
      count_d = count_q + {2'b00, push} - {2'b00, pop};

      unique case (state_q)
         StIdle: begin
            if (fft_finish && !fin_q) begin
               state_d = StRead;
               cnt_d   = '0;
            end
         end
         StRead: begin
            if (occ < 4'(Depth)) begin
               iss_vld_d = 1'b1;
               iss_idx_d = cnt_q;
               if (cnt_q == LastIdx) state_d = StDrain;
               else                  cnt_d   = cnt_q + L_max'(1);
            end
         end
         StDrain: begin
            if (pop && (fifo_idx_q[rd_ptr_q] == LastIdx)) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         fin_q     <= 1'b0;
         cnt_q     <= '0;
         iss_vld_q <= 1'b0;
         iss_idx_q <= '0;
         tag_vld_q <= '0;
         for (int i = 0; i < RD_LAT; i++) tag_idx_q[i] <= '0;
         for (int i = 0; i < Depth; i++) begin
            fifo_re_q[i]  <= '0;
            fifo_im_q[i]  <= '0;
            fifo_idx_q[i] <= '0;
         end
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         fin_q      <= fft_finish;
         cnt_q      <= cnt_d;
         iss_vld_q  <= iss_vld_d;
         iss_idx_q  <= iss_idx_d;
         tag_vld_q  <= tag_vld_d;
         tag_idx_q  <= tag_idx_d;
         fifo_re_q  <= fifo_re_d;
         fifo_im_q  <= fifo_im_d;
         fifo_idx_q <= fifo_idx_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         done_q     <= done_d;
      end
   end

endmodule

// File: tb/tb_fft_result_reader.sv
// Frame-level bench for fft_result_reader: RAM model, per-frame scenario table and a
// beat scoreboard that predicts each bin from the RAM contents and the address order.
module tb_fft_result_reader;

   localparam int unsigned N      = 512;
   localparam int unsigned L_max  = 9;
   localparam int unsigned DW     = 24;
   localparam int unsigned RD_LAT = 1;

   logic             clk;
   logic             rst;
   logic             fft_finish;
   logic [L_max-1:0] read_addr;
   logic [DW-1:0]    dataout_re;
   logic [DW-1:0]    dataout_im;
   logic             out_valid;
   logic             out_ready;
   logic [DW-1:0]    out_re;
   logic [DW-1:0]    out_im;
   logic [L_max-1:0] out_index;
   logic             out_last;
   logic             busy;
   logic             done;

   int tests = 0;
   int fails = 0;

   logic signed [DW-1:0] ram_re [N];
   logic signed [DW-1:0] ram_im [N];

   fft_result_reader #(
      .N      (N),
      .L_max  (L_max),
      .DW     (DW),
      .RD_LAT (RD_LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .fft_finish (fft_finish),
      .read_addr  (read_addr),
      .dataout_re (dataout_re),
      .dataout_im (dataout_im),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_re     (out_re),
      .out_im     (out_im),
      .out_index  (out_index),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous result RAM, one cycle of read latency.
   always_ff @(posedge clk) begin
      dataout_re <= ram_re[read_addr];
      dataout_im <= ram_im[read_addr];
   end

   typedef struct {
      int pct;        // out_ready duty in percent
      int stall;      // cycles of out_ready=0 after the start
      int reedge;     // drop fft_finish at beat 50, raise again at beat 100
      int rst_beat;   // assert reset after this many beats (-1: never)
      int ramp;       // RAM holds re=k, im=-k (else random)
      int exp_beats;
      int exp_done;
   } frame_t;

   frame_t tbl [7];

   function automatic logic [L_max-1:0] addr_of(input int k);
      logic [L_max-1:0] a, r;
      a = L_max'(k);
`ifdef FFT_READER_BITREV_EN
      for (int i = 0; i < L_max; i++) r[i] = a[L_max-1-i];
`else
      r = a;
`endif
      return r;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      chk("rst_valid", longint'(out_valid), 0);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_addr", longint'(read_addr), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_index", longint'(out_index), 0);
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("rst_hold_done", longint'(done), 0);
         chk("rst_hold_busy", longint'(busy), 0);
      end
      fft_finish = 1'b0;
      out_ready  = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic run_frame(input frame_t f);
      int cyc, beats, post, dones;
      logic fin, rdy, pv, prdy;
      logic [2*DW+L_max:0] pvec, cvec;
      logic [L_max-1:0] ea;

      for (int k = 0; k < N; k++) begin
         if (f.ramp != 0) begin
            ram_re[k] = DW'(k);
            ram_im[k] = DW'(-k);
         end else begin
            ram_re[k] = DW'($urandom);
            ram_im[k] = DW'($urandom);
         end
      end

      fft_finish = 1'b1;
      cyc = -1; beats = 0; post = 0; dones = 0;
      fin = 1'b0; pv = 1'b0; prdy = 1'b0; pvec = '0;

      while (1) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc > 20000) begin
            tests++;
            fails++;
            $display("FAIL timeout: frame stuck at beat %0d, want %0d", beats, f.exp_beats);
            break;
         end
         if (f.rst_beat >= 0 && beats == f.rst_beat) begin
            do_reset();
            break;
         end
         if (done) dones++;
         if (fin) begin
            if (post == 0) begin
               chk("done_pulse", longint'(done), 1);
               chk("done_busy", longint'(busy), 0);
               chk("done_valid", longint'(out_valid), 0);
            end else begin
               chk("done_width", longint'(done), 0);
            end
            post++;
            out_ready = 1'b0;
            if (post == 4) break;
            continue;
         end

         chk("busy", longint'(busy), 1);
         chk("no_early_done", longint'(done), 0);
         if (cyc < 3) chk("latency_low", longint'(out_valid), 0);
         if (cyc == 3) chk("latency_first", longint'(out_valid), 1);

         if (f.pct == 100 && f.stall == 0 && cyc >= 1) begin
            ea = (cyc <= N) ? addr_of(cyc - 1) : addr_of(N - 1);
            chk("read_addr", longint'(read_addr), longint'(ea));
            if (cyc > 3) chk("no_gap", longint'(out_valid), 1);
         end
         if (f.stall > 0 && (cyc == 10 || cyc == f.stall)) begin
            chk("stall_addr", longint'(read_addr), longint'(addr_of(3)));
            chk("stall_valid", longint'(out_valid), 1);
            chk("stall_index", longint'(out_index), 0);
         end

         cvec = {out_re, out_im, out_index, out_last};
         if (pv && !prdy) begin
            chk("hold_valid", longint'(out_valid), 1);
            chk("hold_fields", longint'(cvec), longint'(pvec));
         end
         if (out_valid && beats < N) begin
            chk("index", longint'(out_index), longint'(beats));
            chk("re", longint'($signed(out_re)), longint'(ram_re[addr_of(beats)]));
            chk("im", longint'($signed(out_im)), longint'(ram_im[addr_of(beats)]));
            chk("last", longint'(out_last), longint'(beats == N - 1));
         end

         if (f.reedge != 0) begin
            if (beats == 50) fft_finish = 1'b0;
            if (beats == 100) fft_finish = 1'b1;
         end

         rdy = (cyc < f.stall) ? 1'b0 : ($urandom_range(0, 99) < f.pct);
         out_ready = rdy;
         if (out_valid && rdy) begin
            beats++;
            if (beats == N) fin = 1'b1;
         end
         pv = out_valid;
         prdy = rdy;
         pvec = cvec;
      end

      fft_finish = 1'b0;
      out_ready  = 1'b0;
      chk("frame_beats", longint'(beats), longint'(f.exp_beats));
      chk("frame_dones", longint'(dones), longint'(f.exp_done));
   endtask

   initial begin
      tbl[0] = '{100, 0, 0, -1, 1, 512, 1};
      tbl[1] = '{30, 0, 0, -1, 1, 512, 1};
      tbl[2] = '{100, 50, 0, -1, 0, 512, 1};
      tbl[3] = '{100, 0, 1, -1, 0, 512, 1};
      tbl[4] = '{100, 0, 0, -1, 0, 512, 1};
      tbl[5] = '{60, 0, 0, 200, 0, 200, 0};
      tbl[6] = '{100, 0, 0, -1, 1, 512, 1};

      for (int k = 0; k < N; k++) begin
         ram_re[k] = '0;
         ram_im[k] = '0;
      end
      rst        = 1'b0;
      fft_finish = 1'b0;
      out_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_addr", longint'(read_addr), 0);
      chk("reset_valid", longint'(out_valid), 0);
      chk("reset_re", longint'(out_re), 0);
      chk("reset_im", longint'(out_im), 0);
      chk("reset_index", longint'(out_index), 0);
      chk("reset_last", longint'(out_last), 0);
      chk("reset_busy", longint'(busy), 0);
      chk("reset_done", longint'(done), 0);
      @(negedge clk);
      rst = 1'b1;

      repeat (5) @(posedge clk);
      #1;
      chk("idle_busy", longint'(busy), 0);
      chk("idle_valid", longint'(out_valid), 0);

      for (int i = 0; i < 7; i++) begin
         run_frame(tbl[i]);
         repeat (3) @(posedge clk);
         #1;
         chk("gap_busy", longint'(busy), 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
